// File: rtl/image_frame_packer.sv
// Frame packer for the UART image-transmit FIFO: writes sync, width, height,
// the raster pixels and a 16-bit additive pixel checksum, throttled on FIFO fill.
module image_frame_packer #(
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned FIFO_AFULL = 128,
    parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        frame_start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  fifo_wrusedw,
    output logic [15:0] fifo_data,
    output logic        fifo_wrreq,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE, HDR_SYNC, HDR_W, HDR_H, PIXELS, CKSUM
    } state_t;

    localparam logic [15:0] W_WORD = 16'(IMG_W);
    localparam logic [15:0] H_WORD = 16'(IMG_H);
    localparam logic [15:0] W_LAST = 16'(IMG_W - 1);
    localparam logic [15:0] H_LAST = 16'(IMG_H - 1);
    localparam logic [8:0]  AFULL  = 9'(FIFO_AFULL);

    state_t      state, next_state;
    logic [15:0] x_cnt, y_cnt, cksum;
    logic        space, accept, last_pix;

    assign space    = ({1'b0, fifo_wrusedw} < AFULL);
    assign accept   = pix_valid && pix_ready;
    assign last_pix = (x_cnt == W_LAST) && (y_cnt == H_LAST);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (frame_start) next_state = HDR_SYNC;
            HDR_SYNC: if (space) next_state = HDR_W;
            HDR_W:    if (space) next_state = HDR_H;
            HDR_H:    if (space) next_state = PIXELS;
            PIXELS:   if (accept && last_pix) next_state = CKSUM;
            CKSUM:    if (space) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        pix_ready = (state == PIXELS) && space;
    end

    // Write strobe and done are single-cycle; fifo_data keeps its last word.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            fifo_data  <= '0;
            fifo_wrreq <= 1'b0;
            frame_done <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            cksum      <= '0;
        end else begin
            fifo_wrreq <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        x_cnt <= '0;
                        y_cnt <= '0;
                        cksum <= '0;
                    end
                end
                HDR_SYNC: begin
                    if (space) begin
                        fifo_data  <= SYNC_WORD;
                        fifo_wrreq <= 1'b1;
                    end
                end
                HDR_W: begin
                    if (space) begin
                        fifo_data  <= W_WORD;
                        fifo_wrreq <= 1'b1;
                    end
                end
                HDR_H: begin
                    if (space) begin
                        fifo_data  <= H_WORD;
                        fifo_wrreq <= 1'b1;
                    end
                end
                PIXELS: begin
                    if (accept) begin
                        fifo_data  <= pix_data;
                        fifo_wrreq <= 1'b1;
                        cksum      <= cksum + pix_data;
                        if (x_cnt == W_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 16'd1;
                        end else begin
                            x_cnt <= x_cnt + 16'd1;
                        end
                    end
                end
                CKSUM: begin
                    if (space) begin
                        fifo_data  <= cksum;
                        fifo_wrreq <= 1'b1;
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/image_frame_packer.md
# image_frame_packer

Upstream producer for the UART image-transmit path. Accepts a raster stream of 16-bit (RGB565) pixels for one frame and writes framed 16-bit words into the dual-clock transmit FIFO: sync word, width, height, pixels, then a 16-bit checksum. It throttles on the FIFO write-side fill level so the UART controller downstream can drain at line rate without overflow. It replaces the free-running test-pattern counter currently driving the FIFO write port.

## Interface
- IMG_W, 320, pixels per line (1..65535)
- IMG_H, 240, lines per frame (1..65535)
- FIFO_AFULL, 128, write allowed only while fifo_wrusedw < FIFO_AFULL; must be ≤ FIFO depth − 4
- SYNC_WORD, 16'hA55A, first word of every frame
- SYS_CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, asynchronous and active-high
- frame_start  in  1  one-cycle pulse requesting a frame; honoured only in IDLE
- pix_data  in  16  pixel word
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  packer accepts pix_data this cycle
- fifo_wrusedw  in  8  FIFO write-side used words
- fifo_data  out  16  FIFO write data (registered)
- fifo_wrreq  out  1  FIFO write strobe (registered), one word per assertion
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse, coincident with the checksum write

## Operation
- space = (fifo_wrusedw < FIFO_AFULL), combinational.
- States: IDLE, HDR_SYNC, HDR_W, HDR_H, PIXELS, CKSUM.
- IDLE: frame_start=1 → HDR_SYNC; clear x/y counters and checksum. frame_start in any other state is ignored (no queuing).
- HDR_SYNC / HDR_W / HDR_H: when space, register fifo_data = SYNC_WORD / IMG_W[15:0] / IMG_H[15:0], fifo_wrreq=1, advance to next state; else hold with fifo_wrreq=0.
- PIXELS: pix_ready = space (combinational; 0 in all other states). On pix_valid && pix_ready: fifo_data ← pix_data, fifo_wrreq ← 1, checksum ← checksum + pix_data (mod 2^16), x ← x+1; at x = IMG_W−1, x ← 0, y ← y+1; at last pixel (x=IMG_W−1, y=IMG_H−1) → CKSUM.
- CKSUM: when space, fifo_data ← final checksum (including last pixel), fifo_wrreq ← 1, frame_done ← 1, → IDLE.
- Checksum covers pixel words only, not header. Header/checksum are not included in x/y counts.
- Words per frame: 3 + IMG_W·IMG_H + 1.
- fifo_wrreq=0 whenever no write occurs that cycle; fifo_data holds last written value.
- pix_valid while not PIXELS: ignored, never consumed.

## Timing
- Reset: state IDLE, fifo_data=0, fifo_wrreq=0, frame_done=0, busy=0, pix_ready=0, counters and checksum 0. Reset mid-frame aborts the frame immediately; partial frame stays in FIFO (receiver resyncs on SYNC_WORD).
- frame_start sampled at edge N → busy=1 after edge N; with space, SYNC write visible (fifo_wrreq=1) after edge N+1, width after N+2, height after N+3.
- Pixel throughput: one word per cycle when pix_valid=1 and space=1; each accepted pixel appears on fifo_data/fifo_wrreq one cycle after acceptance.
- Checksum write occurs the cycle after the last-pixel write at the earliest; frame_done high for that one cycle; busy falls same edge (IDLE). Earliest next frame_start is that same cycle after return.
- Backpressure: space deasserting stalls the current state with no write and pix_ready=0 in that same cycle; no word dropped or duplicated. wrusedw lag (registered wrreq + FIFO sync) is covered by the FIFO_AFULL margin.
- Counter wrap: x, y, checksum are 16 bits; checksum wraps modulo 2^16 silently.

## Test plan
- IMG_W=4, IMG_H=2, fifo_wrusedw=0, pixels 1..8 continuous → FIFO writes A55A, 0004, 0002, 0001..0008, 0024; 12 consecutive wrreq cycles after frame_start+1; frame_done with 0024.
- Same, fifo_wrusedw=128 held 5 cycles during PIXELS → pix_ready=0, no wrreq for those cycles; resumes with next pixel, sequence unchanged.
- Pixels FFFF, FFFF, 0002 ×6 (IMG_W=4, IMG_H=2) → checksum 000A (wrap).
- frame_start pulsed again during PIXELS → ignored; exactly one frame of 12 words, one frame_done.
- RST asserted after 5 pixels → next cycle all outputs 0, IDLE; new frame_start produces full correct frame starting with A55A.
- pix_valid toggling every other cycle → one pixel write per valid cycle, order preserved, no duplicates.
